opcode_decode_stage: RTL

Registered decode stage between instruction fetch and the control-unit gates. It accepts 32-bit RV32I instructions over a valid/ready handshake and classifies `instr[6:0]` into a one-hot 10-bit opcode code. The code is presented with the instruction, so the downstream gates can AND it against concatenated decoded control data. A 2-entry skid buffer keeps `in_ready` registered and sustains one instruction per cycle under backpressure.

---
 rtl/opcode_decode_stage.sv | 130 +++++++++++++
 1 files changed

// File: rtl/opcode_decode_stage.sv
// Registered RV32I opcode-class decode stage with a 2-entry skid buffer.
// Define OPDEC_ILLEGAL_TRAP_EN to build per-entry illegal-encoding flags.
module opcode_decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [9:0]  out_code,
  output logic        out_illegal
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_FENCE  = 7'b0001111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  logic [9:0]  dec_code;
  logic        m_valid, s_valid;
  logic [31:0] m_instr, s_instr;
  logic [9:0]  m_code, s_code;
  logic        accept, pop, m_free;
  logic        m_load_s, m_load_in, s_load;
  logic        m_valid_nxt, s_valid_nxt;

  always_comb begin
    dec_code = '0;
    if (in_instr[1:0] == 2'b11) begin
      case (in_instr[6:0])
        OPC_LUI:    dec_code[0] = 1'b1;
        OPC_AUIPC:  dec_code[1] = 1'b1;
        OPC_JAL:    dec_code[2] = 1'b1;
        OPC_JALR:   dec_code[3] = 1'b1;
        OPC_BRANCH: dec_code[4] = 1'b1;
        OPC_LOAD:   dec_code[5] = 1'b1;
        OPC_STORE:  dec_code[6] = 1'b1;
        OPC_OPIMM:  dec_code[7] = 1'b1;
        OPC_OP:     dec_code[8] = 1'b1;
        OPC_FENCE,
        OPC_SYSTEM: dec_code[9] = 1'b1;
        default:    dec_code    = '0;
      endcase
    end
  end

  // S only ever holds data while M is full, so M frees up before S drains.
  always_comb begin
    accept      = in_valid & in_ready;
    pop         = m_valid & out_ready;
    m_free      = ~m_valid | pop;
    m_load_s    = m_free & s_valid;
    m_load_in   = m_free & ~s_valid & accept;
    s_load      = accept & ~m_load_in;
    m_valid_nxt = m_free ? (s_valid | accept) : 1'b1;
    s_valid_nxt = s_load | (s_valid & ~m_free);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_valid  <= 1'b0;
      s_valid  <= 1'b0;
      in_ready <= 1'b1;
      m_instr  <= '0;
      m_code   <= '0;
      s_instr  <= '0;
      s_code   <= '0;
    end else if (flush) begin
      m_valid  <= 1'b0;
      s_valid  <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      m_valid  <= m_valid_nxt;
      s_valid  <= s_valid_nxt;
      in_ready <= ~s_valid_nxt;
      if (m_load_s) begin
        m_instr <= s_instr;
        m_code  <= s_code;
      end else if (m_load_in) begin
        m_instr <= in_instr;
        m_code  <= dec_code;
      end
      if (s_load) begin
        s_instr <= in_instr;
        s_code  <= dec_code;
      end
    end
  end

`ifdef OPDEC_ILLEGAL_TRAP_EN
  logic dec_ill, m_ill, s_ill;

  assign dec_ill = ~|dec_code;

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_ill <= 1'b0;
      s_ill <= 1'b0;
    end else if (!flush) begin
      if (m_load_s)
        m_ill <= s_ill;
      else if (m_load_in)
        m_ill <= dec_ill;
      if (s_load)
        s_ill <= dec_ill;
    end
  end

  assign out_illegal = m_valid & m_ill;
`else
  assign out_illegal = 1'b0;
`endif

  assign out_valid = m_valid;
  assign out_instr = m_instr;
  assign out_code  = m_code;

endmodule
